// File: rtl/fifo_sync_param.sv
// rtl/fifo_sync_param.sv - parametrised synchronous FIFO with occupancy, thresholds, flush and sticky error flags
module fifo_sync_param #(
  parameter int WIDTH        = 8,
  parameter int DEPTH        = 16,
  parameter int AFULL_LEVEL  = DEPTH - 2,
  parameter int AEMPTY_LEVEL = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [CW-1:0]    count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [CW-1:0] AFULL_C  = CW'(AFULL_LEVEL);
  localparam logic [CW-1:0] AEMPTY_C = CW'(AEMPTY_LEVEL);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             pop_ok;
  logic             push_ok;

  // Explicit wrap so non-power-of-two depths never index past the last entry.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Flags depend on registered count only, never on the request inputs.
  assign full         = (count == DEPTH_C);
  assign empty        = (count == '0);
  assign almost_full  = (count >= AFULL_C);
  assign almost_empty = (count <= AEMPTY_C);

  // A pop frees a slot in the same cycle, so a full FIFO still takes a push alongside it.
  assign pop_ok  = pop & ~empty;
  assign push_ok = push & (~full | pop_ok);

  always_ff @(posedge clk) begin
    if (push_ok && !flush) begin
      mem[wr_ptr] <= data_in;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      data_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      data_valid <= pop_ok;
      if (pop_ok) begin
        data_out <= mem[rd_ptr];
        rd_ptr   <= ptr_inc(rd_ptr);
      end
      if (push_ok) begin
        wr_ptr <= ptr_inc(wr_ptr);
      end
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push && !push_ok) begin
        overflow <= 1'b1;
      end
      if (pop && !pop_ok) begin
        underflow <= 1'b1;
      end
    end
  end

  a_count_bound : assert property (@(posedge clk) disable iff (!reset) count <= DEPTH_C);
  a_ptr_bound   : assert property (@(posedge clk) disable iff (!reset) (wr_ptr <= LAST_PTR) && (rd_ptr <= LAST_PTR));

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb/tb_fifo_sync_param.sv - scoreboard bench driving a depth-4 and a depth-5 FIFO with shared stimulus
module tb_fifo_sync_param;

  typedef logic [7:0] bq_t [$];

  logic       clk;
  logic       reset;
  logic       flush;
  logic       push;
  logic       pop;
  logic [7:0] data_in;

  logic [7:0] dout_a, dout_b;
  logic       dv_a, dv_b, full_a, full_b, empty_a, empty_b;
  logic       afull_a, afull_b, aempty_a, aempty_b;
  logic       ovf_a, ovf_b, unf_a, unf_b;
  logic [2:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  bq_t        mq_a, mq_b, sb_a, sb_b;
  logic       ovf_m [2];
  logic       unf_m [2];
  logic       dv_m  [2];
  logic [7:0] out_m [2];

  fifo_sync_param #(.WIDTH(8), .DEPTH(4), .AFULL_LEVEL(2), .AEMPTY_LEVEL(2)) u_a (
    .clk(clk), .reset(reset), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
    .data_out(dout_a), .data_valid(dv_a), .full(full_a), .empty(empty_a),
    .almost_full(afull_a), .almost_empty(aempty_a), .count(cnt_a),
    .overflow(ovf_a), .underflow(unf_a)
  );

  fifo_sync_param #(.WIDTH(8), .DEPTH(5)) u_b (
    .clk(clk), .reset(reset), .flush(flush), .push(push), .data_in(data_in), .pop(pop),
    .data_out(dout_b), .data_valid(dv_b), .full(full_b), .empty(empty_b),
    .almost_full(afull_b), .almost_empty(aempty_b), .count(cnt_b),
    .overflow(ovf_b), .underflow(unf_b)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: a plain queue of contents plus the acceptance rules.
  task automatic model_apply(ref bq_t q, ref bq_t sb, input int depth, input int i,
                             input logic p, input logic r, input logic f, input logic [7:0] d);
    int cnt = q.size();
    bit pok, wok;
    if (f) begin
      q.delete();
      ovf_m[i] = 1'b0;
      unf_m[i] = 1'b0;
      dv_m[i]  = 1'b0;
      return;
    end
    pok = r && (cnt > 0);
    wok = p && ((cnt < depth) || pok);
    dv_m[i] = pok;
    if (pok) begin
      out_m[i] = q.pop_front();
      sb.push_back(out_m[i]);
    end
    if (wok) q.push_back(d);
    if (p && !wok) ovf_m[i] = 1'b1;
    if (r && !pok) unf_m[i] = 1'b1;
  endtask

  task automatic model_reset();
    mq_a.delete();
    mq_b.delete();
    for (int i = 0; i < 2; i++) begin
      ovf_m[i] = 1'b0;
      unf_m[i] = 1'b0;
      dv_m[i]  = 1'b0;
      out_m[i] = 8'h00;
    end
  endtask

  task automatic check_inst(input string tag, input int depth, input int af, input int cexp,
                            input int i, input logic [2:0] cnt, input logic fl, input logic em,
                            input logic afl, input logic aem, input logic ov, input logic un,
                            input logic dv, input logic [7:0] dout);
    chk({tag, "_count"}, 32'(cnt), 32'(cexp));
    chk({tag, "_full"}, 32'(fl), 32'(cexp == depth));
    chk({tag, "_empty"}, 32'(em), 32'(cexp == 0));
    chk({tag, "_almost_full"}, 32'(afl), 32'(cexp >= af));
    chk({tag, "_almost_empty"}, 32'(aem), 32'(cexp <= 2));
    chk({tag, "_overflow"}, 32'(ov), 32'(ovf_m[i]));
    chk({tag, "_underflow"}, 32'(un), 32'(unf_m[i]));
    chk({tag, "_data_valid"}, 32'(dv), 32'(dv_m[i]));
    chk({tag, "_data_out"}, 32'(dout), 32'(out_m[i]));
  endtask

  task automatic check_all(input string tag);
    check_inst({tag, "_d4"}, 4, 2, mq_a.size(), 0, cnt_a, full_a, empty_a, afull_a, aempty_a,
               ovf_a, unf_a, dv_a, dout_a);
    check_inst({tag, "_d5"}, 5, 3, mq_b.size(), 1, cnt_b, full_b, empty_b, afull_b, aempty_b,
               ovf_b, unf_b, dv_b, dout_b);
  endtask

  task automatic cycle(input string tag, input logic p, input logic [7:0] d,
                       input logic r, input logic f);
    push = p; data_in = d; pop = r; flush = f;
    model_apply(mq_a, sb_a, 4, 0, p, r, f, d);
    model_apply(mq_b, sb_b, 5, 1, p, r, f, d);
    @(posedge clk);
    @(negedge clk);
    push = 1'b0; pop = 1'b0; flush = 1'b0;
    check_all(tag);
  endtask

  // Monitor: each data_valid must match the oldest word the scoreboard expects.
  initial begin
    forever begin
      @(negedge clk);
      if (dv_a) begin
        if (sb_a.size() == 0) chk("mon_d4_spurious_valid", 32'd1, 32'd0);
        else chk("mon_d4_data", 32'(dout_a), 32'(sb_a.pop_front()));
      end
      if (dv_b) begin
        if (sb_b.size() == 0) chk("mon_d5_spurious_valid", 32'd1, 32'd0);
        else chk("mon_d5_data", 32'(dout_b), 32'(sb_b.pop_front()));
      end
    end
  end

  initial begin
    logic [7:0] seq [4];
    int pushes;
    int c;
    logic p, r;
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;

    reset = 1'b0; flush = 1'b0; push = 1'b0; pop = 1'b0; data_in = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    check_all("reset");
    reset = 1'b1;

    for (int i = 0; i < 4; i++) cycle("fill", 1'b1, seq[i], 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle("drain", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("drain_tail", 1'b0, 8'h00, 1'b0, 1'b0);

    for (int i = 0; i < 4; i++) cycle("refill", 1'b1, seq[i], 1'b0, 1'b0);
    cycle("push_full", 1'b1, 8'h55, 1'b0, 1'b0);
    cycle("push_pop_full", 1'b1, 8'h66, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) cycle("drain2", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 4; i++) cycle("fill3", 1'b1, seq[i], 1'b0, 1'b0);
    cycle("ovf3", 1'b1, 8'h77, 1'b0, 1'b0);
    cycle("pop3", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("flush", 1'b1, 8'hEE, 1'b1, 1'b1);
    cycle("after_flush_push", 1'b1, 8'h3C, 1'b0, 1'b0);
    cycle("after_flush_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("idle", 1'b0, 8'h00, 1'b0, 1'b0);

    cycle("pop_empty", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("push_pop_empty", 1'b1, 8'hA5, 1'b1, 1'b0);
    cycle("pop_a5", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("idle2", 1'b0, 8'h00, 1'b0, 1'b0);

    // Depth-5 wrap run: twelve pushes keeping occupancy within 1..5.
    pushes = 0;
    while (pushes < 12) begin
      c = mq_b.size();
      p = (c == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (c == 0) r = 1'b0;
      if (c == 5 && p) r = 1'b1;
      if (c == 1 && r) p = 1'b1;
      if (p) pushes++;
      cycle("wrap5", p, 8'($urandom), r, 1'b0);
    end
    while (mq_b.size() > 0) cycle("wrap5_drain", 1'b0, 8'h00, 1'b1, 1'b0);

    for (int i = 0; i < 250; i++) begin
      cycle("rand", 1'($urandom_range(0, 2) != 0), 8'($urandom),
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 31) == 0));
    end

    while (mq_b.size() < 3) cycle("pre_rst", 1'b1, 8'($urandom), 1'b0, 1'b0);
    while (mq_b.size() > 3) cycle("pre_rst", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("pre_rst_idle", 1'b0, 8'h00, 1'b0, 1'b0);
    #2 reset = 1'b0;
    #1 model_reset();
    check_all("async_reset");
    @(negedge clk);
    reset = 1'b1;
    cycle("post_reset_push", 1'b1, 8'h5A, 1'b0, 1'b0);
    cycle("post_reset_pop", 1'b0, 8'h00, 1'b1, 1'b0);
    cycle("final_idle", 1'b0, 8'h00, 1'b0, 1'b0);

    chk("sb_d4_leftover", 32'(sb_a.size()), 32'd0);
    chk("sb_d5_leftover", 32'(sb_b.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
